proximity_alert: RTL and testbench

PROXIMITY_ALERT -- requirements
Module: proximity_alert

---
 rtl/neo_ligth_pkg.sv | 27 ++
 rtl/proximity_alert_blink_gen.sv | 51 +++++
 rtl/proximity_alert.sv | 164 ++++++++++++++++
 tb/tb_proximity_alert.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_ligth_pkg.sv
// Shared definitions for the proximity alert block.
// Holds the alert FSM state encoding and the echo-width to centimetre
// conversion constants, plus the conversion helper used by the top level.
package neo_ligth_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALERT   = 2'd2,
        ST_STALE   = 2'd3
    } state_t;

    // dist_cm = (width_us * 1130) >> 16 approximates width_us / 58.
    localparam int CONV_MUL   = 1130;
    localparam int CONV_SHIFT = 16;
    localparam int DIST_SAT   = 255;
    localparam int PROD_W     = 27;   // 65535 * 1130 fits in 27 bits

    function automatic logic [7:0] to_dist_cm(input logic [15:0] width_us);
        logic [PROD_W-1:0]            prod;
        logic [PROD_W-CONV_SHIFT-1:0] scaled;
        prod   = PROD_W'(width_us) * PROD_W'(CONV_MUL);
        scaled = prod[PROD_W-1:CONV_SHIFT];
        to_dist_cm = (scaled > (PROD_W-CONV_SHIFT)'(DIST_SAT)) ? 8'(DIST_SAT) : scaled[7:0];
    endfunction

endpackage

// File: rtl/proximity_alert_blink_gen.sv
// blink_gen: square-wave LED driver used while the alert is active.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   enable        - high while the alert is (being) active
//   half_period   - half-period in BLINK_UNIT steps, sampled at entry and each toggle
//   out           - LED drive; 0 whenever enable is low
module blink_gen #(
    parameter int BLINK_UNIT = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] half_period,
    output logic        out
);

    // Counter must hold half_period * BLINK_UNIT for the largest half_period.
    localparam int CNT_W = 16 + $clog2(BLINK_UNIT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_limit;
    logic             r_out;
    logic             r_active;   // enable seen on the previous edge
    logic [CNT_W-1:0] w_limit;

    assign w_limit = CNT_W'(half_period) * CNT_W'(BLINK_UNIT);
    assign out     = r_out;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            r_cnt    <= '0;
            r_limit  <= '0;
            r_out    <= 1'b0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            // Entry: start high with a fresh count.
            r_cnt    <= '0;
            r_limit  <= w_limit;
            r_out    <= 1'b1;
            r_active <= 1'b1;
        end else if ((r_cnt + CNT_W'(1)) >= r_limit) begin
            // Toggle and re-sample the half-period for the next phase.
            r_cnt   <= '0;
            r_limit <= w_limit;
            r_out   <= ~r_out;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/proximity_alert.sv
// proximity_alert: debounces near/far ranging samples into a confirmed alert,
// converts echo width to centimetres, flags stale input and drives a blink LED
// whose rate follows the measured distance.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   meas_valid             - one-cycle strobe; meas_near/meas_width are valid only
//                            in that cycle. There is no back-pressure: every strobe
//                            is consumed on the edge it is sampled.
//   meas_near, meas_width  - obstacle flag and echo width (us)
//   dist_cm, dist_valid    - converted distance (held) and its update strobe
//   alert, blink, stale    - confirmed obstacle, LED drive, input timeout
//   dbg_state              - current FSM state (neo_ligth_pkg::state_t encoding)
module proximity_alert
    import neo_ligth_pkg::*;
#(
    parameter int CONFIRM_N   = 3,
    parameter int RELEASE_N   = 5,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int BLINK_UNIT  = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        meas_valid,
    input  logic        meas_near,
    input  logic [15:0] meas_width,
    output logic [7:0]  dist_cm,
    output logic        dist_valid,
    output logic        alert,
    output logic        blink,
    output logic        stale,
    output logic [1:0]  dbg_state
);

    localparam int HIT_W  = $clog2(CONFIRM_N + 1);
    localparam int MISS_W = $clog2(RELEASE_N + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);   // counts 0 .. TIMEOUT_CYC-1

    state_t              r_state;
    state_t              w_next_state;
    logic [HIT_W-1:0]    r_hit;
    logic [HIT_W-1:0]    w_next_hit;
    logic [MISS_W-1:0]   r_miss;
    logic [MISS_W-1:0]   w_next_miss;
    logic [IDLE_W-1:0]   r_idle;
    logic                w_timeout;
    logic [7:0]          r_dist;
    logic [7:0]          w_dist_next;
    logic                r_dist_valid;
    logic                r_alert;
    logic                r_stale;
    logic [15:0]         w_half_period;
    logic                w_blink;

    // A sample in the same cycle as expiry wins, so timeout needs !meas_valid.
    assign w_timeout   = !meas_valid && (r_idle == IDLE_W'(TIMEOUT_CYC - 1));
    assign w_dist_next = meas_valid ? to_dist_cm(meas_width) : r_dist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_hit   <= '0;
            r_miss  <= '0;
        end else begin
            r_state <= w_next_state;
            r_hit   <= w_next_hit;
            r_miss  <= w_next_miss;
        end
    end

    // hit/miss never pass their thresholds: reaching one changes state and
    // clears the counter, so they cannot wrap.
    always_comb begin
        w_next_state = r_state;
        w_next_hit   = r_hit;
        w_next_miss  = r_miss;
        if (meas_valid) begin
            case (r_state)
                ST_CLEAR, ST_STALE: begin
                    w_next_miss = '0;
                    if (meas_near) begin
                        if (CONFIRM_N <= 1) begin
                            w_next_state = ST_ALERT;
                            w_next_hit   = '0;
                        end else begin
                            w_next_state = ST_PENDING;
                            w_next_hit   = HIT_W'(1);
                        end
                    end else begin
                        w_next_state = ST_CLEAR;
                        w_next_hit   = '0;
                    end
                end
                ST_PENDING: begin
                    if (meas_near) begin
                        if (r_hit >= HIT_W'(CONFIRM_N - 1)) begin
                            w_next_state = ST_ALERT;
                            w_next_hit   = '0;
                            w_next_miss  = '0;
                        end else begin
                            w_next_hit = r_hit + HIT_W'(1);
                        end
                    end else begin
                        w_next_state = ST_CLEAR;
                        w_next_hit   = '0;
                    end
                end
                ST_ALERT: begin
                    if (meas_near) begin
                        w_next_miss = '0;
                    end else if (r_miss >= MISS_W'(RELEASE_N - 1)) begin
                        w_next_state = ST_CLEAR;
                        w_next_miss  = '0;
                    end else begin
                        w_next_miss = r_miss + MISS_W'(1);
                    end
                end
                default: w_next_state = ST_CLEAR;
            endcase
        end else if (w_timeout) begin
            w_next_state = ST_STALE;
            w_next_hit   = '0;
            w_next_miss  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle       <= '0;
            r_dist       <= '0;
            r_dist_valid <= 1'b0;
            r_alert      <= 1'b0;
            r_stale      <= 1'b0;
        end else begin
            r_idle       <= (meas_valid || w_timeout) ? '0 : r_idle + IDLE_W'(1);
            r_dist       <= w_dist_next;
            r_dist_valid <= meas_valid;
            // Decoded from the next state so the flags change with the state.
            r_alert      <= (w_next_state == ST_ALERT);
            r_stale      <= (w_next_state == ST_STALE);
        end
    end

    // Uses the distance being written this edge so entry and each toggle see
    // the freshest sample.
    assign w_half_period = {8'd0, w_dist_next} + 16'd1;

    blink_gen #(
        .BLINK_UNIT(BLINK_UNIT)
    ) u_blink_gen (
        .clk         (clk),
        .reset       (reset),
        .enable      (w_next_state == ST_ALERT),
        .half_period (w_half_period),
        .out         (w_blink)
    );

    assign dist_cm    = r_dist;
    assign dist_valid = r_dist_valid;
    assign alert      = r_alert;
    assign stale      = r_stale;
    assign blink      = w_blink;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_proximity_alert.sv
// Bench for proximity_alert: directed scenarios plus randomized traffic
// compared against a behavioural model of the alert rules.
module tb_proximity_alert;

    localparam int CONFIRM_N   = 3;
    localparam int RELEASE_N   = 5;
    localparam int TIMEOUT_CYC = 1000;
    localparam int BLINK_UNIT  = 10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        meas_valid = 1'b0;
    logic        meas_near = 1'b0;
    logic [15:0] meas_width = 16'd0;
    logic [7:0]  dist_cm;
    logic        dist_valid;
    logic        alert;
    logic        blink;
    logic        stale;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    proximity_alert #(
        .CONFIRM_N   (CONFIRM_N),
        .RELEASE_N   (RELEASE_N),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .BLINK_UNIT  (BLINK_UNIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .meas_valid (meas_valid),
        .meas_near  (meas_near),
        .meas_width (meas_width),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .alert      (alert),
        .blink      (blink),
        .stale      (stale),
        .dbg_state  (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    // ---------------- behavioural model ----------------
    // Tracks the rules directly: run lengths of near/far samples, cycles
    // since the last sample, and a countdown to the next blink toggle.
    int   m_dist = 0;
    bit   m_dv = 0;
    bit   m_alert = 0;
    bit   m_stale = 0;
    int   m_near_run = 0;
    int   m_far_run = 0;
    int   m_idle = 0;
    bit   m_blink = 0;
    int   m_blink_left = 0;

    function automatic int conv_cm(input int width_us);
        int d;
        d = (width_us * 1130) / 65536;
        return (d > 255) ? 255 : d;
    endfunction

    task automatic model_edge(input logic rst, input logic v, input logic n, input logic [15:0] w);
        bit was_alert;
        if (rst) begin
            m_dist = 0; m_dv = 0; m_alert = 0; m_stale = 0;
            m_near_run = 0; m_far_run = 0; m_idle = 0;
            m_blink = 0; m_blink_left = 0;
            return;
        end
        was_alert = m_alert;
        m_dv = v;
        if (v) begin
            m_dist = conv_cm(int'(w));
            m_idle = 0;
            if (m_alert) begin
                m_far_run = n ? 0 : m_far_run + 1;
                if (m_far_run == RELEASE_N) begin
                    m_alert = 0; m_far_run = 0; m_near_run = 0;
                end
            end else begin
                m_stale = 0;
                m_near_run = n ? m_near_run + 1 : 0;
                if (m_near_run == CONFIRM_N) begin
                    m_alert = 1; m_near_run = 0; m_far_run = 0;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
                m_idle = 0; m_stale = 1; m_alert = 0;
                m_near_run = 0; m_far_run = 0;
            end
        end
        if (m_alert && !was_alert) begin
            m_blink = 1;
            m_blink_left = (m_dist + 1) * BLINK_UNIT;
        end else if (m_alert) begin
            m_blink_left--;
            if (m_blink_left == 0) begin
                m_blink = !m_blink;
                m_blink_left = (m_dist + 1) * BLINK_UNIT;
            end
        end else begin
            m_blink = 0;
        end
    endtask

    function automatic logic [14:0] model_vec();
        logic [1:0] st;
        st = m_stale ? 2'd3 : m_alert ? 2'd2 : (m_near_run > 0) ? 2'd1 : 2'd0;
        return {m_dist[7:0], m_dv, m_alert, m_blink, m_stale, st};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic n, input logic [15:0] w);
        meas_valid = v;
        meas_near  = n;
        meas_width = w;
        @(posedge clk);
        model_edge(reset, v, n, w);
        #1;
        meas_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 16'd0);
    endtask

    // Steps until blink changes; returns the number of edges taken (600 = gave up).
    task automatic measure_half(output int cycles);
        logic start;
        start  = blink;
        cycles = 0;
        while (blink === start && cycles < 600) begin
            step(1'b0, 1'b0, 16'd0);
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 16'd2320);
        step(1'b1, 1'b1, 16'd2320);
        total++;
        if ({dist_cm, dist_valid, alert, blink, stale} !== 12'd0) begin
            bad++;
            $display("FAIL reset_outputs: got dist=%0d dv=%0b alert=%0b blink=%0b stale=%0b, want all 0",
                     dist_cm, dist_valid, alert, blink, stale);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", dbg_state);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_conversion();
        logic [15:0] widths[4];
        widths[0] = 16'd1160; widths[1] = 16'd2320; widths[2] = 16'd0; widths[3] = 16'd65535;
        exp_q.push_back(8'd20); exp_q.push_back(8'd40);
        exp_q.push_back(8'd0);  exp_q.push_back(8'd255);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_d;
            exp_d = exp_q.pop_front();
            step(1'b1, 1'b0, widths[i]);
            total++;
            if (dist_valid !== 1'b1 || dist_cm !== exp_d) begin
                bad++;
                $display("FAIL conv_%0d: got dist=%0d dv=%0b want dist=%0d dv=1", i, dist_cm, dist_valid, exp_d);
            end
            step(1'b0, 1'b0, 16'hBEEF);
            total++;
            if (dist_valid !== 1'b0 || dist_cm !== exp_d) begin
                bad++;
                $display("FAIL conv_hold_%0d: got dist=%0d dv=%0b want dist=%0d dv=0", i, dist_cm, dist_valid, exp_d);
            end
        end
    endtask

    task automatic test_confirm();
        step(1'b1, 1'b1, 16'd1160);
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if (alert !== 1'b0 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL confirm_pending: got alert=%0b state=%0d want 0/1", alert, dbg_state);
        end
        step(1'b1, 1'b0, 16'd1160);
        total++;
        if (alert !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL confirm_reject: got alert=%0b state=%0d want 0/0", alert, dbg_state);
        end
        step(1'b1, 1'b1, 16'd1160);
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if (alert !== 1'b0) begin
            bad++;
            $display("FAIL confirm_early: got alert=%0b want 0", alert);
        end
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if (alert !== 1'b1 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL confirm_raise: got alert=%0b state=%0d want 1/2", alert, dbg_state);
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'd1160);
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if (alert !== 1'b1) begin
            bad++;
            $display("FAIL release_far4_near: got alert=%0b want 1", alert);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'd1160);
        total++;
        if (alert !== 1'b1) begin
            bad++;
            $display("FAIL release_far4: got alert=%0b want 1", alert);
        end
        step(1'b1, 1'b0, 16'd1160);
        total++;
        if (alert !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL release_far5: got alert=%0b state=%0d want 0/0", alert, dbg_state);
        end
    endtask

    task automatic test_blink();
        int n;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd1160);
        total++;
        if (blink !== 1'b1) begin
            bad++;
            $display("FAIL blink_entry: got blink=%0b want 1", blink);
        end
        measure_half(n);
        total++;
        if (n != 210) begin
            bad++;
            $display("FAIL blink_half_20: got %0d cycles want 210", n);
        end
        // New sample (dist 4) partway through a phase: this phase keeps 210.
        idle(20);
        step(1'b1, 1'b1, 16'd232);
        measure_half(n);
        total++;
        if (n + 21 != 210) begin
            bad++;
            $display("FAIL blink_half_cur: got %0d cycles want 210", n + 21);
        end
        measure_half(n);
        total++;
        if (n != 50) begin
            bad++;
            $display("FAIL blink_half_4: got %0d cycles want 50", n);
        end
    endtask

    task automatic test_timeout();
        step(1'b1, 1'b1, 16'd1160);
        idle(TIMEOUT_CYC - 1);
        total++;
        if (stale !== 1'b0 || alert !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got stale=%0b alert=%0b want 0/1", stale, alert);
        end
        idle(1);
        total++;
        if (stale !== 1'b1 || alert !== 1'b0 || blink !== 1'b0 || dbg_state !== 2'd3) begin
            bad++;
            $display("FAIL timeout_stale: got stale=%0b alert=%0b blink=%0b state=%0d want 1/0/0/3",
                     stale, alert, blink, dbg_state);
        end
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if (stale !== 1'b0 || dbg_state !== 2'd1) begin
            bad++;
            $display("FAIL stale_exit: got stale=%0b state=%0d want 0/1", stale, dbg_state);
        end
        idle(TIMEOUT_CYC - 1);
        step(1'b1, 1'b0, 16'd100);
        total++;
        if (stale !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL timeout_coincide: got stale=%0b state=%0d want 0/0", stale, dbg_state);
        end
        idle(TIMEOUT_CYC - 1);
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL timeout_restart: got stale=%0b want 0", stale);
        end
        idle(1);
        total++;
        if (stale !== 1'b1) begin
            bad++;
            $display("FAIL timeout_from_clear: got stale=%0b want 1", stale);
        end
    endtask

    task automatic test_reset_mid_alert();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'd1160);
        total++;
        if (alert !== 1'b1 || blink !== 1'b1) begin
            bad++;
            $display("FAIL mid_alert_setup: got alert=%0b blink=%0b want 1/1", alert, blink);
        end
        reset = 1'b1;
        step(1'b1, 1'b1, 16'd1160);
        total++;
        if ({dist_cm, dist_valid, alert, blink, stale, dbg_state} !== 14'd0) begin
            bad++;
            $display("FAIL reset_mid_alert: got dist=%0d dv=%0b alert=%0b blink=%0b stale=%0b state=%0d want all 0",
                     dist_cm, dist_valid, alert, blink, stale, dbg_state);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int den;
        logic [14:0] got;
        logic [14:0] exp_v;
        for (int seg = 0; seg < 6; seg++) begin
            den = (seg % 3 == 0) ? 4 : (seg % 3 == 1) ? 40 : 1500;
            for (int c = 0; c < 1500; c++) begin
                logic v, n;
                logic [15:0] w;
                v = ($urandom_range(0, den - 1) == 0);
                n = ($urandom_range(0, 2) != 0);
                w = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 2500));
                reset = ($urandom_range(0, 999) == 0);
                step(v, n, w);
                got   = {dist_cm, dist_valid, alert, blink, stale, dbg_state};
                exp_v = model_vec();
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL random seg=%0d cyc=%0d: got {dist,dv,alert,blink,stale,st}=%h want %h",
                             seg, c, got, exp_v);
                end
            end
        end
        reset = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_conversion();
        test_confirm();
        test_release();
        test_blink();
        test_timeout();
        test_reset_mid_alert();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
